demux16_1x9_reg: RTL and testbench
==================================

# demux16_1x9_reg

- Registered 1-to-9 demultiplexer for 16-bit words; the write-side counterpart of the 9:1 word selector.
- Accepts one word per cycle on a valid/ready input port and steers it by a 4-bit select into one of nine single-entry output holding registers.
- Each output register has its own valid/ready handshake.
- Select codes 9–15 are rejected: the word is dropped and an error is flagged.

## Interface
Parameters:
- WIDTH, 16, data word width; the select width is fixed at 4 and the channel count at 9.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  input word.
- in_sel  in  4  destination channel; 0–8 are valid, 9–15 are invalid.
- in_valid  in  1  in_data and in_sel are valid.
- in_ready  out  1  block can accept this cycle; combinational from in_sel, channel state and out_ready.
- out_data  out  9*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  9  channel k holding register is full.
- out_ready  in  9  downstream of channel k accepts.
- err_sel  out  1  one-cycle pulse, registered, when a word with in_sel > 8 is accepted and dropped.
- err_count  out  8  saturating count of dropped words.

## Operation
- Each channel k is a two-state machine: EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
- Input handshake:
  - Input fire = in_valid && in_ready.
  - For in_sel ≤ 8: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - For in_sel > 8: in_ready = 1. Invalid words are always consumed so they never stall the input.
- Input fire with in_sel = k ≤ 8: next cycle channel k is FULL and out_data[k] = in_data.
- Output fire on channel k = out_valid[k] && out_ready[k]:
  - Without an input fire to k in the same cycle, channel k goes EMPTY and out_data[k] returns to all-ones.
  - With an input fire to k in the same cycle, channel k stays FULL with the new word. This gives back-to-back throughput of 1 word/cycle per channel.
- Only one channel can be written per cycle. Any number of channels can drain in the same cycle.
- An EMPTY channel drives all-ones (16'hFFFF for WIDTH=16) on its out_data slice.
- A FULL channel holds its data stable until its output fire. out_data and out_valid must not change while out_valid=1 && out_ready=0.
- Invalid select (in_sel > 8) with input fire:
  - No channel changes.
  - err_sel = 1 on the next cycle.
  - err_count increments, saturating at 255.
- in_ready ignores in_valid. When in_valid=0 nothing is written, whatever in_ready shows.

## Timing
- Reset (rst_n=0, asynchronous): all out_valid = 0, all out_data = all-ones, err_sel = 0, err_count = 0.
- During reset in_ready is don't-care; no input fire is taken.
- Reset asserted mid-transfer discards all held words immediately. No partial word survives.
- Latency: input fire at edge N → out_valid[k] = 1 and data visible after edge N+1 (one register stage).
- Drain-and-refill of a FULL channel in one cycle: the old word leaves and the new word is visible after the same edge. There is no bubble.
- err_sel is high for exactly one cycle per dropped word. Consecutive dropped words give err_sel high for consecutive cycles.
- There are no combinational paths from in_data to any output. The only combinational path is from in_sel/out_ready to in_ready.

## Configuration
- DEMUX_ERR_CNT_EN
  - Defined: err_count is the 8-bit saturating drop counter described above.
  - Not defined: the counter is not built and err_count is tied to 0.
  - err_sel pulse and drop behaviour are identical in both builds.

## Test plan
- Reset then idle: out_valid = 9'h000, every out_data slice = 16'hFFFF, err_count = 0, in_ready = 1 for every in_sel.
- Write 16'h1234 with sel=3, out_ready=0 → after one edge out_valid = 9'h008 and slice 3 = 16'h1234. A second write with sel=3 sees in_ready = 0 and the held data is unchanged. Raise out_ready[3] → that word drains and in_ready goes back to 1.
- Streaming: sel=8 with out_ready[8]=1 and words 16'h0001..16'h0005 on consecutive cycles → slice 8 shows each word one cycle later, out_valid[8] stays high for 5 cycles with no gaps, then clears and the slice returns to 16'hFFFF.
- Invalid selects 4'hA and 4'hF with in_valid → in_ready = 1, no out_valid change, err_sel pulses twice, and err_count = 2 with DEMUX_ERR_CNT_EN defined (0 without). 300 invalid words → err_count = 255.
- Concurrent drain: fill channels 0, 4 and 7 (data 16'hAAAA, 16'h5555, 16'h0F0F), then assert out_ready = 9'h091 for one cycle → all three clear together and their slices read 16'hFFFF.
- Reset mid-operation: with channels 2 and 5 FULL, pulse rst_n low between clock edges → out_valid clears immediately (asynchronously), slices read 16'hFFFF, and err_count = 0.

Source files
------------

// File: rtl/demux16_1x9_reg.sv
// Registered 1-to-9 demultiplexer: steers one valid/ready word per cycle into one of nine
// single-entry output holding registers. Define DEMUX_ERR_CNT_EN to build the drop counter.
module demux16_1x9_reg #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [3:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [9*WIDTH-1:0] out_data,
    output logic [8:0]         out_valid,
    input  logic [8:0]         out_ready,
    output logic               err_sel,
    output logic [7:0]         err_count
);

    localparam int NCH = 9;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_e;

    ch_state_e                  state_q [NCH];
    ch_state_e                  state_d [NCH];
    logic [NCH-1:0][WIDTH-1:0]  data_q;
    logic [NCH-1:0][WIDTH-1:0]  data_d;
    logic                       sel_ok;
    logic                       in_fire;
    logic                       err_sel_q;

    assign sel_ok  = (in_sel <= 4'd8);
    assign in_fire = in_valid && in_ready;

    // Invalid selects are always accepted so they can be dropped without stalling.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        in_ready = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (in_sel == 4'(k)) begin
                in_ready = (state_q[k] == EMPTY) || out_ready[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (in_fire && (in_sel == 4'(k))) begin
                // A write in the same cycle as a drain refills without a bubble.
                state_d[k] = FULL;
                data_d[k]  = in_data;
            end else if ((state_q[k] == FULL) && out_ready[k]) begin
                state_d[k] = EMPTY;
                data_d[k]  = '1;
            end
        end
    end

    // NOTE: the data registers are reset as well, because an EMPTY channel must read all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '1;
            end
            err_sel_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            err_sel_q <= in_valid && !sel_ok;
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            out_valid[k] = (state_q[k] == FULL);
        end
    end

    assign out_data = data_q;
    assign err_sel  = err_sel_q;

`ifdef DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (in_valid && !sel_ok && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_demux16_1x9_reg.sv
// Scoreboard bench for demux16_1x9_reg: stimulus pushes expected words per channel, a
// negedge monitor pops and compares them whenever a channel drains.
module tb_demux16_1x9_reg;

    localparam int WIDTH = 16;

`ifdef DEMUX_ERR_CNT_EN
    localparam logic [7:0] EXP_CNT2   = 8'd2;
    localparam logic [7:0] EXP_CNTSAT = 8'd255;
`else
    localparam logic [7:0] EXP_CNT2   = 8'd0;
    localparam logic [7:0] EXP_CNTSAT = 8'd0;
`endif

    logic               clk;
    logic               rst_n;
    logic [WIDTH-1:0]   in_data;
    logic [3:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [9*WIDTH-1:0] out_data;
    logic [8:0]         out_valid;
    logic [8:0]         out_ready;
    logic               err_sel;
    logic [7:0]         err_count;

    typedef struct {
        int          ch;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   err_pending = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    demux16_1x9_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] slice(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] sel, input logic [15:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        if (sel <= 4'd8) exp_q.push_back('{ch: int'(sel), data: data});
        else err_pending++;
    endtask

    // Monitor: every drain pops the oldest expected word for that channel.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 9; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (idx < 0 && exp_q[i].ch == k) idx = i;
                    end
                    if (idx < 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL drain ch%0d: got %0h expected no word", k, slice(k));
                    end else begin
                        check($sformatf("drain ch%0d", k), 32'(slice(k)), 32'(exp_q[idx].data));
                        exp_q.delete(idx);
                    end
                end
            end
            if (err_sel) begin
                if (err_pending == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL err_sel: got 1 expected 0");
                end else begin
                    n_tests++;
                    err_pending--;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 4'd0;
        in_data   = 16'h0000;
        out_ready = 9'h000;

        // Reset state
        #12;
        check("rst out_valid", 32'(out_valid), 32'h0);
        for (int k = 0; k < 9; k++) check($sformatf("rst slice%0d", k), 32'(slice(k)), 32'hFFFF);
        check("rst err_count", 32'(err_count), 32'h0);
        check("rst err_sel", 32'(err_sel), 32'h0);
        rst_n = 1'b1;
        tick();

        for (int s = 0; s < 16; s++) begin
            in_sel = 4'(s);
            #1;
            check($sformatf("idle in_ready sel%0d", s), 32'(in_ready), 32'h1);
        end

        // Single write, backpressure, drain
        send(4'd3, 16'h1234);
        #1;
        check("wr3 in_ready", 32'(in_ready), 32'h1);
        tick();
        in_data = 16'hBEEF;
        #1;
        check("wr3 out_valid", 32'(out_valid), 32'h008);
        check("wr3 slice3", 32'(slice(3)), 32'h1234);
        check("full3 in_ready", 32'(in_ready), 32'h0);
        tick();
        check("hold3 out_valid", 32'(out_valid), 32'h008);
        check("hold3 slice3", 32'(slice(3)), 32'h1234);
        in_valid  = 1'b0;
        out_ready = 9'h008;
        #1;
        check("drain3 in_ready", 32'(in_ready), 32'h1);
        tick();
        check("drained3 out_valid", 32'(out_valid), 32'h000);
        check("drained3 slice3", 32'(slice(3)), 32'hFFFF);
        out_ready = 9'h000;

        // Streaming on channel 8
        out_ready = 9'h100;
        for (int i = 1; i <= 5; i++) begin
            send(4'd8, 16'(i));
            tick();
            check($sformatf("stream v%0d", i), 32'(out_valid[8]), 32'h1);
            check($sformatf("stream d%0d", i), 32'(slice(8)), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream end valid", 32'(out_valid), 32'h000);
        check("stream end slice8", 32'(slice(8)), 32'hFFFF);
        out_ready = 9'h000;

        // Invalid selects
        send(4'hA, 16'hDEAD);
        #1;
        check("selA in_ready", 32'(in_ready), 32'h1);
        tick();
        check("selA out_valid", 32'(out_valid), 32'h000);
        check("selA err_sel", 32'(err_sel), 32'h1);
        send(4'hF, 16'hDEAD);
        #1;
        check("selF in_ready", 32'(in_ready), 32'h1);
        tick();
        check("selF err_sel", 32'(err_sel), 32'h1);
        in_valid = 1'b0;
        tick();
        check("err_sel low", 32'(err_sel), 32'h0);
        check("err_count 2", 32'(err_count), 32'(EXP_CNT2));
        check("inv out_valid", 32'(out_valid), 32'h000);

        for (int i = 0; i < 300; i++) begin
            send(4'(9 + (i % 7)), 16'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("err_count sat", 32'(err_count), 32'(EXP_CNTSAT));

        // Concurrent drain of channels 0, 4, 7
        send(4'd0, 16'hAAAA);
        tick();
        send(4'd4, 16'h5555);
        tick();
        send(4'd7, 16'h0F0F);
        tick();
        in_valid = 1'b0;
        check("fill047 out_valid", 32'(out_valid), 32'h091);
        out_ready = 9'h091;
        tick();
        out_ready = 9'h000;
        check("drain047 out_valid", 32'(out_valid), 32'h000);
        check("drain047 slice0", 32'(slice(0)), 32'hFFFF);
        check("drain047 slice4", 32'(slice(4)), 32'hFFFF);
        check("drain047 slice7", 32'(slice(7)), 32'hFFFF);

        // Asynchronous reset mid-operation; held words are discarded, not drained.
        in_valid = 1'b1;
        in_sel   = 4'd2;
        in_data  = 16'h2222;
        tick();
        in_sel   = 4'd5;
        in_data  = 16'h5555;
        tick();
        in_valid = 1'b0;
        check("fill25 out_valid", 32'(out_valid), 32'h024);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst out_valid", 32'(out_valid), 32'h000);
        check("arst slice2", 32'(slice(2)), 32'hFFFF);
        check("arst slice5", 32'(slice(5)), 32'hFFFF);
        check("arst err_count", 32'(err_count), 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        tick();

        check("scoreboard empty", 32'(exp_q.size()), 32'h0);
        check("err pulses consumed", 32'(err_pending), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
